// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared ALU operation codes, ALUOp encoding and funct7 constant.
//             Used by the decode stage and by the ALU itself.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // 4-bit operation codes understood by the ALU. NOR is reserved: the
  // decode stage never produces it.
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_NOR  = 4'b1100
  } alu_op_t;

  // Main-control ALUOp field.
  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_t;

  // funct7 value selecting the alternate operation (SUB / SRA).
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

endpackage
`default_nettype wire

// File: rtl/alu_control_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_control_stage_if
//  Brief    : Upstream op bus and downstream ALU bus of the ALU control stage,
//             both with valid/ready handshakes, plus the illegal-op counter.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_control_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_aluop;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [XLEN-1:0]  in_imm;
  logic             in_alusrc;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_operation;
  logic [XLEN-1:0]  out_a;
  logic [XLEN-1:0]  out_b;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;

  // Environment side: issues ops and accepts ALU transfers.
  modport master (
    output in_valid, in_aluop, in_funct3, in_funct7, in_rs1, in_rs2, in_imm,
           in_alusrc, out_ready,
    input  in_ready, out_valid, out_operation, out_a, out_b, out_illegal,
           illegal_count
  );

  // Stage side.
  modport slave (
    input  in_valid, in_aluop, in_funct3, in_funct7, in_rs1, in_rs2, in_imm,
           in_alusrc, out_ready,
    output in_ready, out_valid, out_operation, out_a, out_b, out_illegal,
           illegal_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decode
//  Brief    : Combinational ALUOp/funct3/funct7 to ALU operation decode with
//             illegal-encoding detection. Illegal ops decode to ADD.
//  Revision : 1.0  initial release
// ============================================================================
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output alu_op_t    o_operation,
  output logic       o_illegal
);

  logic w_rtype;
  logic w_f7_base;
  logic w_f7_alt;

  assign w_rtype   = (aluop_t'(i_aluop) == ALUOP_RTYPE);
  assign w_f7_base = (i_funct7 == 7'b0000000);
  assign w_f7_alt  = (i_funct7 == FUNCT7_ALT);

  // Legality of funct-driven encodings; load/store and branch are always legal.
  always_comb begin
    o_illegal = 1'b0;
    if (i_aluop[1]) begin
      if (w_rtype) begin
        o_illegal = !(w_f7_base ||
                      (w_f7_alt && (i_funct3 == 3'b000 || i_funct3 == 3'b101)));
      end else if (i_funct3 == 3'b001) begin
        o_illegal = !w_f7_base;
      end else if (i_funct3 == 3'b101) begin
        o_illegal = !(w_f7_base || w_f7_alt);
      end
    end
  end

  // Operation select; an illegal encoding passes through as ADD.
  always_comb begin
    o_operation = OP_ADD;
    case (aluop_t'(i_aluop))
      ALUOP_MEM:    o_operation = OP_ADD;
      ALUOP_BRANCH: o_operation = OP_SUB;
      default: begin
        case (i_funct3)
          3'b000:  o_operation = (w_rtype && w_f7_alt) ? OP_SUB : OP_ADD;
          3'b001:  o_operation = OP_SLL;
          3'b010:  o_operation = OP_SLT;
          3'b011:  o_operation = OP_SLTU;
          3'b100:  o_operation = OP_XOR;
          3'b101:  o_operation = w_f7_alt ? OP_SRA : OP_SRL;
          3'b110:  o_operation = OP_OR;
          default: o_operation = OP_AND;
        endcase
        if (o_illegal) begin
          o_operation = OP_ADD;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_control_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_control_stage
//  Brief    : Registered decode stage ahead of the ALU. Decodes the operation,
//             selects operand B, and hands {op, A, B} downstream through a
//             2-entry (main + skid) buffer. Counts accepted illegal ops.
//  Revision : 1.0  initial release
// ============================================================================
module alu_control_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  alu_control_stage_if.slave bus
);

  // Buffer occupancy states.
  localparam logic [1:0] c_st_empty = 2'd0;
  localparam logic [1:0] c_st_one   = 2'd1;
  localparam logic [1:0] c_st_full  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_xfer;

  alu_op_t          w_dec_op;
  logic             w_dec_ill;
  logic [XLEN-1:0]  w_in_b;

  alu_op_t          r_main_op;
  logic             r_main_ill;
  logic [XLEN-1:0]  r_main_a;
  logic [XLEN-1:0]  r_main_b;
  alu_op_t          r_skid_op;
  logic             r_skid_ill;
  logic [XLEN-1:0]  r_skid_a;
  logic [XLEN-1:0]  r_skid_b;
  logic [CNT_W-1:0] r_cnt;

  alu_decode u_decode (
    .i_aluop     (bus.in_aluop),
    .i_funct3    (bus.in_funct3),
    .i_funct7    (bus.in_funct7),
    .o_operation (w_dec_op),
    .o_illegal   (w_dec_ill)
  );

  assign w_in_b   = bus.in_alusrc ? bus.in_imm : bus.in_rs2;
  assign w_accept = bus.in_valid & w_in_ready;
  assign w_xfer   = w_out_valid & bus.out_ready;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_st_empty;
    else       r_state <= w_state_nxt;
  end

  // Occupancy transitions driven by accept/transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_empty: if (w_accept) w_state_nxt = c_st_one;
      c_st_one: begin
        if (w_accept && !w_xfer)      w_state_nxt = c_st_full;
        else if (w_xfer && !w_accept) w_state_nxt = c_st_empty;
      end
      c_st_full:  if (w_xfer) w_state_nxt = c_st_one;
      default:    w_state_nxt = c_st_empty;
    endcase
  end

  // Handshake outputs from occupancy only; reset forces the idle handshake.
  always_comb begin
    w_in_ready  = (r_state != c_st_full) | reset;
    w_out_valid = (r_state != c_st_empty) & ~reset;
  end

  // Main register: loads a new op, reloads on simultaneous accept/transfer,
  // or takes the skid entry when the full buffer drains by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_op  <= OP_ADD;
      r_main_ill <= 1'b0;
      r_main_a   <= '0;
      r_main_b   <= '0;
    end else if (((r_state == c_st_empty) && w_accept) ||
                 ((r_state == c_st_one) && w_accept && w_xfer)) begin
      r_main_op  <= w_dec_op;
      r_main_ill <= w_dec_ill;
      r_main_a   <= bus.in_rs1;
      r_main_b   <= w_in_b;
    end else if ((r_state == c_st_full) && w_xfer) begin
      r_main_op  <= r_skid_op;
      r_main_ill <= r_skid_ill;
      r_main_a   <= r_skid_a;
      r_main_b   <= r_skid_b;
    end
  end

  // Skid register: catches the op accepted while the main entry is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid_op  <= OP_ADD;
      r_skid_ill <= 1'b0;
      r_skid_a   <= '0;
      r_skid_b   <= '0;
    end else if ((r_state == c_st_one) && w_accept && !w_xfer) begin
      r_skid_op  <= w_dec_op;
      r_skid_ill <= w_dec_ill;
      r_skid_a   <= bus.in_rs1;
      r_skid_b   <= w_in_b;
    end
  end

  // Saturating count of accepted illegal ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept && w_dec_ill && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_operation = r_main_op;
  assign bus.out_a         = r_main_a;
  assign bus.out_b         = r_main_b;
  assign bus.out_illegal   = r_main_ill;
  assign bus.illegal_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_control_stage
//  Brief    : Self-checking bench for alu_control_stage: directed scenarios
//             followed by randomized traffic against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_control_stage;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  alu_control_stage_if #(.XLEN(32), .CNT_W(16)) bus  ();
  alu_control_stage_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  alu_control_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_control_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
  } item_t;

  item_t exp_q[$];
  int    cnt_m = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result of one op, straight from the decode rules.
  function automatic item_t ref_item(input logic [1:0] aluop, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] rs1,
                                     input logic [31:0] rs2, input logic [31:0] imm,
                                     input logic src);
    item_t it;
    logic [3:0] base_op [8] = '{4'h2, 4'h4, 4'h7, 4'h9, 4'h3, 4'h5, 4'h1, 4'h0};
    bit is_r = (aluop == 2'b10);
    bit zero = (f7 == 7'd0);
    bit alt  = (f7 == 7'h20);
    bit bad;
    it.a = rs1;
    it.b = src ? imm : rs2;
    it.ill = 1'b0;
    if (aluop == 2'b00) begin
      it.op = 4'h2;
    end else if (aluop == 2'b01) begin
      it.op = 4'h6;
    end else begin
      if (is_r) bad = !(zero || (alt && (f3 == 3'd0 || f3 == 3'd5)));
      else      bad = (f3 == 3'd1 && !zero) || (f3 == 3'd5 && !(zero || alt));
      it.op = base_op[f3];
      if (is_r && alt && f3 == 3'd0) it.op = 4'h6;
      if (alt && f3 == 3'd5)         it.op = 4'h8;
      if (bad) begin
        it.op  = 4'h2;
        it.ill = 1'b1;
      end
    end
    return it;
  endfunction

  task automatic drive(input logic v, input logic [1:0] aluop, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic src, input logic ordy);
    bus.in_valid  = v;
    bus.in_aluop  = aluop;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    bus.in_alusrc = src;
    bus.out_ready = ordy;
  endtask

  // One clock: compare against the model mid-cycle, advance the model, step.
  task automatic cycle();
    int    n;
    item_t it;
    @(negedge clk);
    n = exp_q.size();
    check("in_ready", 64'(bus.in_ready), 64'(n < 2));
    check("out_valid", 64'(bus.out_valid), 64'(n != 0));
    check("illegal_count", 64'(bus.illegal_count), 64'(cnt_m));
    if (n != 0) begin
      check("out_operation", 64'(bus.out_operation), 64'(exp_q[0].op));
      check("out_illegal", 64'(bus.out_illegal), 64'(exp_q[0].ill));
      check("out_a", 64'(bus.out_a), 64'(exp_q[0].a));
      check("out_b", 64'(bus.out_b), 64'(exp_q[0].b));
    end
    if (bus.in_valid && n < 2) begin
      it = ref_item(bus.in_aluop, bus.in_funct3, bus.in_funct7, bus.in_rs1,
                    bus.in_rs2, bus.in_imm, bus.in_alusrc);
      exp_q.push_back(it);
      if (it.ill && cnt_m < 65535) cnt_m++;
    end
    if (n != 0 && bus.out_ready) void'(exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    #1;
    check("rst_out_valid_during", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready_during", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    cnt_m = 0;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_operation", 64'(bus.out_operation), 64'(4'b0010));
    check("rst_a", 64'(bus.out_a), 64'(0));
    check("rst_b", 64'(bus.out_b), 64'(0));
    check("rst_illegal", 64'(bus.out_illegal), 64'(0));
    check("rst_count", 64'(bus.illegal_count), 64'(0));
  endtask

  initial begin
    logic [6:0] f7r;
    drive(1'b0, 2'b00, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    bus2.in_aluop  = 2'b10;
    bus2.in_funct3 = 3'b001;
    bus2.in_funct7 = 7'h20;
    bus2.in_rs1    = 32'd0;
    bus2.in_rs2    = 32'd0;
    bus2.in_imm    = 32'd0;
    bus2.in_alusrc = 1'b0;
    bus2.out_ready = 1'b1;
    do_reset();

    // R-type ADD, one-cycle latency.
    drive(1'b1, 2'b10, 3'b000, 7'd0, 32'd197, 32'hFFFFFF13, 32'd0, 1'b0, 1'b1);
    cycle();
    check("t1_valid", 64'(bus.out_valid), 64'(1));
    check("t1_op", 64'(bus.out_operation), 64'(4'b0010));
    check("t1_a", 64'(bus.out_a), 64'(197));
    check("t1_b", 64'(bus.out_b), 64'(32'hFFFFFF13));
    check("t1_ill", 64'(bus.out_illegal), 64'(0));

    // SUB, SRA (I-type), branch.
    drive(1'b1, 2'b10, 3'b000, 7'h20, 32'd197, 32'hFFFFFF13, 32'd0, 1'b0, 1'b1);
    cycle();
    check("t2_sub", 64'(bus.out_operation), 64'(4'b0110));
    drive(1'b1, 2'b11, 3'b101, 7'h20, 32'd7, 32'd0, 32'd3, 1'b1, 1'b1);
    cycle();
    check("t2_sra", 64'(bus.out_operation), 64'(4'b1000));
    drive(1'b1, 2'b01, 3'b111, 7'h7F, 32'd9, 32'd8, 32'd0, 1'b0, 1'b1);
    cycle();
    check("t2_branch", 64'(bus.out_operation), 64'(4'b0110));

    // Immediate operand B.
    drive(1'b1, 2'b00, 3'b010, 7'd0, 32'd40, 32'd1, 32'hFFFFFFFB, 1'b1, 1'b1);
    cycle();
    check("t3_op", 64'(bus.out_operation), 64'(4'b0010));
    check("t3_b", 64'(bus.out_b), 64'(32'hFFFFFFFB));
    drive(1'b0, 2'b00, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    cycle();

    // Backpressure: fill main + skid, third op refused, then ordered drain.
    drive(1'b1, 2'b10, 3'b100, 7'd0, 32'd101, 32'd1, 32'd0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 2'b10, 3'b110, 7'd0, 32'd102, 32'd2, 32'd0, 1'b0, 1'b0);
    cycle();
    check("t4_in_ready_full", 64'(bus.in_ready), 64'(0));
    check("t4_hold_a", 64'(bus.out_a), 64'(101));
    drive(1'b1, 2'b10, 3'b111, 7'd0, 32'd103, 32'd3, 32'd0, 1'b0, 1'b0);
    cycle();
    check("t4_still_hold_a", 64'(bus.out_a), 64'(101));
    bus.out_ready = 1'b1;
    cycle();
    check("t4_second_a", 64'(bus.out_a), 64'(102));
    check("t4_in_ready_back", 64'(bus.in_ready), 64'(1));
    cycle();
    check("t4_third_a", 64'(bus.out_a), 64'(103));
    bus.in_valid = 1'b0;
    cycle();
    check("t4_drained", 64'(bus.out_valid), 64'(0));

    // Illegal op passes as ADD and is counted.
    drive(1'b1, 2'b10, 3'b001, 7'h20, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1);
    cycle();
    check("t5_ill", 64'(bus.out_illegal), 64'(1));
    check("t5_op", 64'(bus.out_operation), 64'(4'b0010));
    check("t5_count", 64'(bus.illegal_count), 64'(1));
    bus.in_valid = 1'b0;
    cycle();

    // Reset while full: buffered ops are discarded.
    drive(1'b1, 2'b10, 3'b000, 7'd0, 32'd201, 32'd1, 32'd0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 2'b10, 3'b000, 7'd0, 32'd202, 32'd2, 32'd0, 1'b0, 1'b0);
    cycle();
    check("t6_full", 64'(bus.in_ready), 64'(0));
    do_reset();
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       f7r = 7'd0;
        1:       f7r = 7'h20;
        default: f7r = 7'($urandom);
      endcase
      drive(($urandom_range(0, 9) < 7), 2'($urandom), 3'($urandom), f7r,
            $urandom, $urandom, $urandom, 1'($urandom), ($urandom_range(0, 9) < 6));
      cycle();
    end
    drive(1'b0, 2'b00, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle();

    // Saturation of a 2-bit counter.
    bus2.in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      check("sat_count", 64'(bus2.illegal_count), 64'((i < 3) ? i : 3));
      check("sat_ill", 64'(bus2.out_illegal), 64'(1));
    end
    bus2.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
